// File: rtl/reset_pkg.sv
// Shared definitions for the reset scheduler: FSM encoding, default timing, counter width.
package reset_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   // Wait / check counter width; covers both the full wait and the lock timeout.
   localparam int CNT_W = 24;

   localparam int unsigned DEF_FULL_CYCLES  = 32'd8500021;
   localparam int unsigned DEF_PART_CYCLES  = 32'd11;
   localparam int unsigned DEF_LOCK_TIMEOUT = 32'd400000;
   localparam int unsigned DEF_MAX_RETRY    = 32'd3;
   localparam int unsigned DEF_LOSS_FILT    = 32'd4;

endpackage

// File: rtl/lock_loss_filter.sv
// Consecutive-low filter on dcm_locked; emits a one-cycle loss pulse on the
// LOSS_FILT-th consecutive low sample while enabled.
module lock_loss_filter #(
   parameter int unsigned LOSS_FILT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic locked_i,
   output logic loss_o
);

   localparam int CW = $clog2(LOSS_FILT + 1);
   localparam logic [CW-1:0] LAST_LOW = CW'(LOSS_FILT - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [CW-1:0] low_cnt_q;

   // Loss fires on the cycle holding LOSS_FILT-1 earlier lows plus a current low.
   assign loss_o = en_i && !locked_i && (low_cnt_q == LAST_LOW);

   // Count consecutive low samples; any high, disable or fired loss restarts the run.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         low_cnt_q <= '0;
      end else if (!en_i || locked_i || loss_o) begin
         low_cnt_q <= '0;
      end else begin
         low_cnt_q <= low_cnt_q + ONE;
      end
   end

endmodule

// File: rtl/reset_sched.sv
// Reset scheduler in front of the 40 MHz DCM/IDELAY reset sequencer: arbitrates
// power-on, host and lock-loss requests, models sequencer busy time, checks DCM
// lock after full resets with bounded retry, and reports status.
//
// Request semantics: host_full_req / host_idelay_req are levels sampled on every
// clk40 edge; each sampled-high cycle latches a pending flag (no ready/ack). The
// trigger outputs are single-cycle pulses with no back-pressure from the sequencer.
module reset_sched
   import reset_pkg::*;
#(
   parameter int unsigned FULL_CYCLES  = DEF_FULL_CYCLES,
   parameter int unsigned PART_CYCLES  = DEF_PART_CYCLES,
   parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
   parameter int unsigned LOSS_FILT    = DEF_LOSS_FILT
) (
   input  logic       clk40,
   input  logic       rst,
   input  logic       host_full_req,
   input  logic       host_idelay_req,
   input  logic       dcm_locked,
   output logic       full_rst_trig,
   output logic       idelay_rst_trig,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic [1:0] retry_cnt,
   output logic [7:0] loss_cnt,
   output state_t     state_dbg
);

   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(FULL_CYCLES - 1);
   localparam logic [CNT_W-1:0] PART_LOAD = CNT_W'(PART_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

   state_t           state_q;
   logic             serve_full_q;  // sequence in flight is a full reset
   logic             pend_full_q;
   logic             pend_idle_q;
   logic             lock_ok_q;
   logic [CNT_W-1:0] cnt_q;
   logic             full_trig_q;
   logic             idel_trig_q;
   logic             busy_q;
   logic             done_q;
   logic             fail_q;
   logic [1:0]       retry_q;
   logic [7:0]       loss_q;

   logic       loss;
   logic       mon_en;
   logic       idle_req_ok;
   logic [1:0] retry_d;
   logic [7:0] loss_d;

   // Lock is only supervised while idle after a verified lock.
   assign mon_en      = (state_q == ST_IDLE) && lock_ok_q;
   // An idelay request is dropped while failed or while a full reset is active.
   assign idle_req_ok = !fail_q && !(serve_full_q && (state_q != ST_IDLE));
   assign retry_d     = retry_q + 2'd1;
   assign loss_d      = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

   lock_loss_filter #(
      .LOSS_FILT(LOSS_FILT)
   ) u_loss_filt (
      .clk_i   (clk40),
      .rst_i   (rst),
      .en_i    (mon_en),
      .locked_i(dcm_locked),
      .loss_o  (loss)
   );

   // Scheduler FSM with registered outputs; request/loss updates come last so they win.
   always_ff @(posedge clk40 or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         serve_full_q <= 1'b0;
         pend_full_q  <= 1'b1;
         pend_idle_q  <= 1'b0;
         lock_ok_q    <= 1'b0;
         cnt_q        <= '0;
         full_trig_q  <= 1'b0;
         idel_trig_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         retry_q      <= 2'd0;
         loss_q       <= 8'd0;
      end else begin
         full_trig_q <= 1'b0;
         idel_trig_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pend_full_q) begin
                  state_q      <= ST_ISSUE;
                  serve_full_q <= 1'b1;
                  full_trig_q  <= 1'b1;
                  busy_q       <= 1'b1;
               end else if (pend_idle_q) begin
                  state_q      <= ST_ISSUE;
                  serve_full_q <= 1'b0;
                  idel_trig_q  <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            ST_ISSUE: begin
               // A full reset includes the idelay reset, so both flags clear.
               pend_idle_q <= 1'b0;
               if (serve_full_q) begin
                  pend_full_q <= 1'b0;
               end
               cnt_q   <= serve_full_q ? FULL_LOAD : PART_LOAD;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  if (serve_full_q) begin
                     cnt_q   <= '0;
                     state_q <= ST_CHECK;
                  end else begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            ST_CHECK: begin
               if (dcm_locked) begin
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  lock_ok_q <= 1'b1;
                  retry_q   <= 2'd0;
                  state_q   <= ST_IDLE;
               end else if (cnt_q == TIMEOUT) begin
                  retry_q <= retry_d;
                  if (retry_d == RETRY_LIM) begin
                     fail_q    <= 1'b1;
                     lock_ok_q <= 1'b0;
                     busy_q    <= 1'b0;
                     state_q   <= ST_IDLE;
                  end else begin
                     full_trig_q <= 1'b1;
                     state_q     <= ST_ISSUE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         if (loss) begin
            pend_full_q <= 1'b1;
            lock_ok_q   <= 1'b0;
            loss_q      <= loss_d;
         end
         if (host_full_req) begin
            pend_full_q <= 1'b1;
            fail_q      <= 1'b0;
            retry_q     <= 2'd0;
         end
         if (host_idelay_req && idle_req_ok) begin
            pend_idle_q <= 1'b1;
         end
      end
   end

   assign full_rst_trig   = full_trig_q;
   assign idelay_rst_trig = idel_trig_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign fail            = fail_q;
   assign retry_cnt       = retry_q;
   assign loss_cnt        = loss_q;
   assign state_dbg       = state_q;

endmodule

// File: tb/tb_reset_sched.sv
// Bench for reset_sched with shortened timing. Expected trigger/done cycles come
// from the externally visible timing rules; observed events are captured by a
// negedge monitor into queues and compared after each step.
module tb_reset_sched;
  import reset_pkg::*;

  localparam int FULL = 20;
  localparam int PART = 11;
  localparam int TMO  = 8;
  localparam int MAXR = 2;
  localparam int LF   = 3;
  // Trigger to re-trigger: 1 issue cycle + FULL wait + (TMO+1) check cycles.
  localparam int RETRY_GAP = 1 + FULL + TMO + 1;

  // ---------------- clock / reset ----------------
  logic clk40 = 1'b0;
  logic rst = 1'b0;
  logic host_full_req = 1'b0;
  logic host_idelay_req = 1'b0;
  logic dcm_locked = 1'b1;
  logic full_rst_trig, idelay_rst_trig, busy, done, fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  state_t state_dbg;

  always #5 clk40 = ~clk40;

  reset_sched #(
    .FULL_CYCLES(FULL), .PART_CYCLES(PART), .LOCK_TIMEOUT(TMO),
    .MAX_RETRY(MAXR), .LOSS_FILT(LF)
  ) dut (
    .clk40(clk40), .rst(rst), .host_full_req(host_full_req),
    .host_idelay_req(host_idelay_req), .dcm_locked(dcm_locked),
    .full_rst_trig(full_rst_trig), .idelay_rst_trig(idelay_rst_trig),
    .busy(busy), .done(done), .fail(fail), .retry_cnt(retry_cnt),
    .loss_cnt(loss_cnt), .state_dbg(state_dbg)
  );

  // Cycle k is the period following the k-th clock edge after reset release.
  int cyc = 0;
  always @(posedge clk40 or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_full_q[$];
  logic [31:0] exp_idel_q[$];
  logic [31:0] exp_done_q[$];
  logic [31:0] act_full_q[$];
  logic [31:0] act_idel_q[$];
  logic [31:0] act_done_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int model_loss = 0;

  always @(negedge clk40) begin
    if (rst === 1'b0) begin
      if (full_rst_trig === 1'b1)   act_full_q.push_back(cyc);
      if (idelay_rst_trig === 1'b1) act_idel_q.push_back(cyc);
      if (done === 1'b1)            act_done_q.push_back(cyc);
    end
  end

  // Reference timing: e is the edge at which the request is sampled.
  function automatic int full_done_at(input int e);
    return e + 1 + FULL + 2;
  endfunction
  function automatic int idel_done_at(input int e);
    return e + 1 + PART + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic compare_events(input string tag);
    chk({tag, "_nfull"}, act_full_q.size(), exp_full_q.size());
    for (int i = 0; i < exp_full_q.size() && i < act_full_q.size(); i++)
      chk({tag, "_full_cyc"}, act_full_q[i], exp_full_q[i]);
    chk({tag, "_nidel"}, act_idel_q.size(), exp_idel_q.size());
    for (int i = 0; i < exp_idel_q.size() && i < act_idel_q.size(); i++)
      chk({tag, "_idel_cyc"}, act_idel_q[i], exp_idel_q[i]);
    chk({tag, "_ndone"}, act_done_q.size(), exp_done_q.size());
    for (int i = 0; i < exp_done_q.size() && i < act_done_q.size(); i++)
      chk({tag, "_done_cyc"}, act_done_q[i], exp_done_q[i]);
    exp_full_q.delete(); exp_idel_q.delete(); exp_done_q.delete();
    act_full_q.delete(); act_idel_q.delete(); act_done_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk40);
  endtask

  // One-cycle request pulse; e returns the edge at which it is sampled.
  task automatic pulse(input bit f, input bit i, output int e);
    e = cyc + 1;
    host_full_req = f;
    host_idelay_req = i;
    @(negedge clk40);
    host_full_req = 1'b0;
    host_idelay_req = 1'b0;
  endtask

  // Hold dcm_locked low for d sampled edges; c is the cycle before the first low sample.
  task automatic drop_lock(input int d, output int c);
    c = cyc;
    dcm_locked = 1'b0;
    tick(d);
    dcm_locked = 1'b1;
  endtask

  task automatic settle(input string tag, input int budget);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk40);
      n++;
      if (busy === 1'b0 && full_rst_trig === 1'b0 && idelay_rst_trig === 1'b0) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s_settle: busy after %0d cycles, required idle", tag, budget);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_full_trig"}, full_rst_trig, 0);
    chk({tag, "_idel_trig"}, idelay_rst_trig, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
    chk({tag, "_loss"}, loss_cnt, 0);
    chk({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e, e2, c, k, d, op, gap, first_b, last_b, nbusy;
    string tag;

    // Power-on reset, then automatic full reset with lock present.
    #1 rst = 1'b1;
    tick(3);
    chk_all_zero("por");
    rst = 1'b0;
    exp_full_q.push_back(1);
    exp_done_q.push_back(full_done_at(0));
    settle("por", 100);
    compare_events("por");

    // Idelay request sampled at edge 100, with busy window.
    tick(99 - cyc);
    pulse(1'b0, 1'b1, e);
    exp_idel_q.push_back(e + 1);
    exp_done_q.push_back(idel_done_at(e));
    first_b = -1; last_b = -1; nbusy = 0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk40);
      if (busy === 1'b1) begin
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
        nbusy++;
      end
    end
    chk("idel_busy_first", first_b, e + 1);
    chk("idel_busy_last", last_b, idel_done_at(e) - 1);
    chk("idel_busy_len", nbusy, PART + 1);
    settle("idel", 100);
    compare_events("idel");

    // Simultaneous full + idelay: one full trigger only.
    pulse(1'b1, 1'b1, e);
    exp_full_q.push_back(e + 1);
    exp_done_q.push_back(full_done_at(e));
    settle("both", 100);
    compare_events("both");

    // Short lock glitch is filtered; LF lows cause a loss and a full reset.
    drop_lock(LF - 1, c);
    settle("glitch", 100);
    compare_events("glitch");
    chk("glitch_loss", loss_cnt, model_loss);
    drop_lock(LF, c);
    exp_full_q.push_back(c + LF + 1);
    exp_done_q.push_back(full_done_at(c + LF));
    model_loss++;
    settle("loss", 100);
    compare_events("loss");
    chk("loss_cnt1", loss_cnt, model_loss);

    // Randomized mix of requests and lock drops.
    for (int it = 0; it < 14; it++) begin
      op = $urandom_range(0, 5);
      gap = $urandom_range(0, 6);
      tick(gap);
      case (op)
        0: begin
          pulse(1'b0, 1'b1, e);
          exp_idel_q.push_back(e + 1);
          exp_done_q.push_back(idel_done_at(e));
        end
        1: begin
          pulse(1'b1, 1'b0, e);
          exp_full_q.push_back(e + 1);
          exp_done_q.push_back(full_done_at(e));
        end
        2: begin
          pulse(1'b1, 1'b1, e);
          exp_full_q.push_back(e + 1);
          exp_done_q.push_back(full_done_at(e));
        end
        3: begin
          // Full request during idelay wait runs right after the idelay sequence.
          pulse(1'b0, 1'b1, e);
          k = $urandom_range(2, 12);
          tick(k - 1);
          pulse(1'b1, 1'b0, e2);
          exp_idel_q.push_back(e + 1);
          exp_done_q.push_back(idel_done_at(e));
          exp_full_q.push_back(idel_done_at(e) + 1);
          exp_done_q.push_back(full_done_at(idel_done_at(e)));
        end
        4: begin
          // Idelay request during a pending/active full reset is absorbed.
          pulse(1'b1, 1'b0, e);
          k = $urandom_range(1, 22);
          tick(k - 1);
          pulse(1'b0, 1'b1, e2);
          exp_full_q.push_back(e + 1);
          exp_done_q.push_back(full_done_at(e));
        end
        default: begin
          d = $urandom_range(1, 5);
          drop_lock(d, c);
          if (d >= LF) begin
            exp_full_q.push_back(c + LF + 1);
            exp_done_q.push_back(full_done_at(c + LF));
            if (model_loss < 255) model_loss++;
          end
        end
      endcase
      tag = $sformatf("rand%0d_op%0d", it, op);
      settle(tag, 200);
      compare_events(tag);
      chk({tag, "_loss"}, loss_cnt, model_loss);
      chk({tag, "_fail"}, fail, 0);
    end

    // Lock never arrives: MAXR attempts, then sticky fail.
    dcm_locked = 1'b0;
    pulse(1'b1, 1'b0, e);
    for (int a = 0; a < MAXR; a++) exp_full_q.push_back(e + 1 + a * RETRY_GAP);
    tick(31);
    chk("retry_mid_cnt", retry_cnt, 1);
    chk("retry_mid_busy", busy, 1);
    settle("retry_fail", 300);
    chk("fail_set", fail, 1);
    chk("fail_retry", retry_cnt, MAXR);
    chk("fail_busy", busy, 0);
    compare_events("retry_fail");
    pulse(1'b0, 1'b1, e);
    settle("fail_idel", 100);
    compare_events("fail_idel");
    chk("fail_hold", fail, 1);
    chk("fail_loss", loss_cnt, model_loss);
    dcm_locked = 1'b1;
    pulse(1'b1, 1'b0, e);
    chk("fail_clr", fail, 0);
    chk("fail_clr_retry", retry_cnt, 0);
    exp_full_q.push_back(e + 1);
    exp_done_q.push_back(full_done_at(e));
    settle("recover", 100);
    compare_events("recover");

    // Lock arrives during the second attempt.
    dcm_locked = 1'b0;
    pulse(1'b1, 1'b0, e);
    tick(31);
    chk("retry2_cnt", retry_cnt, 1);
    tick(3);
    dcm_locked = 1'b1;
    exp_full_q.push_back(e + 1);
    exp_full_q.push_back(e + 1 + RETRY_GAP);
    exp_done_q.push_back(full_done_at(e + RETRY_GAP));
    settle("retry_ok", 200);
    compare_events("retry_ok");
    chk("retry_ok_cnt", retry_cnt, 0);
    chk("retry_ok_fail", fail, 0);

    // Loss counter saturation.
    for (int s = 0; s < 256; s++) begin
      drop_lock(LF, c);
      exp_full_q.push_back(c + LF + 1);
      exp_done_q.push_back(full_done_at(c + LF));
      if (model_loss < 255) model_loss++;
      settle("sat", 100);
    end
    compare_events("sat");
    chk("loss_sat", loss_cnt, model_loss);

    // Reset mid-wait aborts at once; power-on full reset follows release.
    pulse(1'b1, 1'b0, e);
    exp_full_q.push_back(e + 1);
    tick(11);
    chk("mid_busy", busy, 1);
    compare_events("mid_pre");
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    tick(3);
    rst = 1'b0;
    model_loss = 0;
    exp_full_q.push_back(1);
    exp_done_q.push_back(full_done_at(0));
    settle("mid_post", 100);
    compare_events("mid_post");
    chk("mid_post_loss", loss_cnt, model_loss);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sched.md
# reset_sched

Scheduler in front of the 40 MHz reset sequencer (DCM + IDELAYCTRL/IDELAY reset). It arbitrates power-on, host and lock-loss reset requests and issues single-cycle `full_rst_trig` / `idelay_rst_trig` pulses to the sequencer. It models the sequencer's busy time with its own counter, verifies DCM lock after full resets with bounded retry, and reports status to the host register bank.

## Interface
Parameters:
- `FULL_CYCLES`, 8500021: cycles from full trigger until the sequencer is idle again.
- `PART_CYCLES`, 11: cycles from idelay trigger until the sequencer is idle again.
- `LOCK_TIMEOUT`, 400000: cycles (10 ms) allowed for `dcm_locked` after the full wait.
- `MAX_RETRY`, 3: full-reset attempts before declaring failure.
- `LOSS_FILT`, 4: consecutive low `dcm_locked` cycles that count as a lock loss.

Ports:
- `clk40` in 1: 40 MHz clock, the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `host_full_req` in 1: host request for a full reset (level, sampled).
- `host_idelay_req` in 1: host request for an idelay-only reset.
- `dcm_locked` in 1: DCM lock, already synchronous to `clk40`.
- `full_rst_trig` out 1: one-cycle pulse to the sequencer.
- `idelay_rst_trig` out 1: one-cycle pulse to the sequencer.
- `busy` out 1: a sequence is in flight or being checked.
- `done` out 1: one-cycle pulse when a sequence completes successfully.
- `fail` out 1: sticky; lock not achieved after `MAX_RETRY` attempts.
- `retry_cnt` out 2: attempts used in the current full sequence.
- `loss_cnt` out 8: saturating count of detected lock losses.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK.
- Pending flags `pend_full` and `pend_idle` are set by requests in any state.
- `rst` forces:
  - every output to 0 and the state to IDLE;
  - `pend_full` to 1, so a power-on full reset issues automatically after reset release;
  - `pend_idle` and `lock_ok` to 0.
- IDLE:
  - If `pend_full`, go to ISSUE(full).
  - Else if `pend_idle`, go to ISSUE(idelay).
  - Full has priority over idelay.
- ISSUE:
  - Pulse the matching trigger for exactly 1 cycle.
  - Clear the served pending flag. Serving full also clears `pend_idle`, because a full reset includes the idelay reset.
  - Load the wait counter and go to WAIT.
- WAIT:
  - Count down `FULL_CYCLES` or `PART_CYCLES`. The counter is 24-bit.
  - At 0: after a full reset go to CHECK. After an idelay reset, pulse `done` and go to IDLE.
- CHECK:
  - Count up to `LOCK_TIMEOUT`.
  - If `dcm_locked` is high: pulse `done`, set `lock_ok`, clear `retry_cnt`, go to IDLE.
  - On timeout, increment `retry_cnt`. If it equals `MAX_RETRY`: set `fail`, clear `lock_ok`, go to IDLE. Otherwise go to ISSUE(full).
- Lock-loss monitor:
  - Active only in IDLE with `lock_ok`.
  - `dcm_locked` low for `LOSS_FILT` consecutive cycles sets `pend_full`, clears `lock_ok` and increments `loss_cnt`. `loss_cnt` saturates at 255.
- `host_full_req` clears `fail` and `retry_cnt`.
- `host_idelay_req` while `fail` is set is ignored.
- Requests arriving during WAIT/CHECK are never dropped. The exception is an idelay request absorbed by a pending or active full reset.
- A full request during an idelay WAIT is served immediately after that sequence completes.

## Timing
- Request sampled high at edge N → trigger high during cycle N+1 (IDLE→ISSUE takes one edge).
- `busy` rises together with the trigger.
- Idelay path: `done` at cycle N+1+`PART_CYCLES`+1; `busy` falls on the same edge.
- Full path with lock already present: `done` at cycle N+1+`FULL_CYCLES`+2.
- `busy` stays high through retries. The re-trigger comes 1 cycle after the timeout.
- Simultaneous full and idelay requests produce one full trigger only.
- Asserting `rst` mid-sequence aborts immediately with no trigger pulse. A power-on full reset follows release.

## Structure
- Package `reset_pkg`: state encoding, default cycle constants, counter width (24).
- Sub-module `lock_loss_filter`: consecutive-low counter with enable; outputs a one-cycle `loss` pulse.

## Test plan
All scenarios use sim parameters FULL=20, PART=11, TIMEOUT=8, MAX_RETRY=2, LOSS_FILT=3.
- Release `rst` with `dcm_locked`=1 → one `full_rst_trig` at cycle 1, `done` at cycle 23, no `idelay_rst_trig`.
- `host_idelay_req` pulse at cycle 100 → `idelay_rst_trig` at 101, `done` at 113, `busy` high cycles 101–112.
- `host_full_req` and `host_idelay_req` in the same cycle → exactly one `full_rst_trig`, zero `idelay_rst_trig`.
- `dcm_locked` held 0 → two full triggers 30 cycles apart, then `fail`=1, `retry_cnt`=2, `busy`=0. A following `host_full_req` clears `fail`.
- After success, drop `dcm_locked` for 2 cycles → no action. Drop it for 3 cycles → `loss_cnt`=1 and a full trigger on the following cycle+1.
- `rst` asserted at WAIT count 10 → outputs 0 at once. After release, a new full trigger and `loss_cnt`=0.
